// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing ROM read port B among NUM_REQ requesters, with bounded lock bursts and flush.
// Latency: grant is combinational in cycle T; rvalid/rdata arrive in cycle T+1 (one access per cycle sustained).
// Backpressure: none downstream; a requester holds req/addr until granted, and a flush blocks the grant so the request retries.
module rom_port_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         lock_i,
    input  logic [NUM_REQ*WIDTH-1:0]   addr_i,
    input  logic                       flush_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       rom_en_o,
    output logic                       rom_flush_o,
    output logic [WIDTH-1:0]           rom_addr_o,
    input  logic [WIDTH-1:0]           rom_rd_i
);
    localparam int         IW  = $clog2(NUM_REQ);
    localparam logic [3:0] CAP = 4'(MAX_BURST - 1);

    logic [IW-1:0]      last;
    logic [IW-1:0]      win;
    logic [IW-1:0]      sel;
    logic [IW-1:0]      rr_idx;
    logic [NUM_REQ-1:0] owner_q;
    logic [3:0]         burst_cnt;
    logic               locked;
    logic               lock_hit;
    logic               rr_found;
    logic               grant;

    // Scan last+1, last+2, ... modulo NUM_REQ; works for non power-of-two counts.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        rr_found = 1'b0;
        rr_idx   = last;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(last) + i) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!rr_found && req_i[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        lock_hit = locked && req_i[last] && (burst_cnt < CAP);
        grant    = rst_n && !flush_i && (lock_hit || rr_found);
        win      = lock_hit ? last : rr_idx;
        sel      = grant ? win : last;
        gnt_o    = '0;
        if (grant) begin
            gnt_o[win] = 1'b1;
        end
    end

    assign rom_en_o    = grant;
    assign rom_flush_o = flush_i && rst_n;
    assign rom_addr_o  = addr_i[int'(sel)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= IW'(NUM_REQ - 1);
            owner_q   <= '0;
            burst_cnt <= '0;
            locked    <= 1'b0;
        end else begin
            owner_q <= gnt_o;
            if (grant) begin
                last   <= win;
                locked <= lock_i[win];
                // A repeat win at the cap restarts the count so the lock can be honoured again later.
                if (lock_hit) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end else if ((win != last) || (burst_cnt >= CAP)) begin
                    burst_cnt <= '0;
                end else begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end else begin
                locked <= 1'b0;
            end
        end
    end

    assign rvalid_o = owner_q;
    assign rdata_o  = (|owner_q) ? rom_rd_i : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: stimulus queues expected grants/responses, a negedge monitor compares.
module tb_rom_port_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic       flush;
        logic [31:0] addr;
    } gexp_t;

    typedef struct {
        int         cyc;
        logic [3:0] vld;
        logic [31:0] dat;
    } rexp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [N-1:0]   lock_i = '0;
    logic [N*W-1:0] addr_i = '0;
    logic           flush_i = 1'b0;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   rvalid_o;
    logic [W-1:0]   rdata_o;
    logic           rom_en_o;
    logic           rom_flush_o;
    logic [W-1:0]   rom_addr_o;
    logic [W-1:0]   rom_rd;

    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    gexp_t gq[$];
    rexp_t rq[$];

    rom_port_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .lock_i(lock_i), .addr_i(addr_i),
        .flush_i(flush_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .rom_en_o(rom_en_o), .rom_flush_o(rom_flush_o), .rom_addr_o(rom_addr_o),
        .rom_rd_i(rom_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] addr_of(int i);
        return 32'h1000 + 32'(i) * 32'h44 + 32'(i);
    endfunction

    function automatic logic [31:0] word_of(logic [31:0] a);
        return 32'hD000_0000 | (a >> 2);
    endfunction

    // Registered ROM read port: word select ignores byte bits, flush clears the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rom_rd <= '0;
        else if (rom_flush_o) rom_rd <= '0;
        else if (rom_en_o)   rom_rd <= word_of(rom_addr_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            check("gnt", 32'(gnt_o), 32'(g.gnt));
            check("rom_en", 32'(rom_en_o), 32'(|g.gnt));
            check("rom_flush", 32'(rom_flush_o), 32'(g.flush));
            if (g.gnt != 0) check("rom_addr", rom_addr_o, g.addr);
        end
        if (rvalid_o != 0) begin
            if (rq.size() == 0) begin
                check("unexpected_rvalid", 32'(rvalid_o), 32'd0);
            end else begin
                r = rq.pop_front();
                check("resp_cycle", 32'(cyc), 32'(r.cyc));
                check("rvalid", 32'(rvalid_o), 32'(r.vld));
                check("rdata", rdata_o, r.dat);
            end
        end else begin
            check("rdata_idle", rdata_o, 32'd0);
        end
    end

    task automatic step(input logic [3:0] req, input logic [3:0] lock, input logic flush, input int w);
        gexp_t g;
        rexp_t r;
        req_i   = req;
        lock_i  = lock;
        flush_i = flush;
        g.cyc   = cyc;
        g.gnt   = (w >= 0) ? 4'(1 << w) : 4'b0000;
        g.flush = flush & rst_n;
        g.addr  = (w >= 0) ? addr_of(w) : 32'h0;
        gq.push_back(g);
        if (w >= 0) begin
            r.cyc = cyc + 1;
            r.vld = g.gnt;
            r.dat = word_of(addr_of(w));
            rq.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    int burst_exp[9] = '{1, 2, 2, 2, 2, 3, 1, 2, 2};

    initial begin
        for (int i = 0; i < N; i++) addr_i[i*W +: W] = addr_of(i);
        @(posedge clk);
        #1;
        // All requesting while held in reset: nothing may be granted.
        step(4'b1111, 4'b0000, 1'b0, -1);
        step(4'b1111, 4'b0000, 1'b0, -1);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step(4'b1111, 4'b0000, 1'b0, k % 4);
        step(4'b0000, 4'b0000, 1'b0, -1);
        // Requester 2 locked with 1 and 3 competing: burst capped at four grants.
        for (int k = 0; k < 9; k++) step(4'b1110, 4'b0100, 1'b0, burst_exp[k]);
        // Locked owner drops its request: port released the same cycle.
        step(4'b1011, 4'b0000, 1'b0, 3);
        step(4'b0000, 4'b0000, 1'b0, -1);
        // Flush blocks the grant; a later flush does not cancel the prior response.
        step(4'b0010, 4'b0000, 1'b1, -1);
        step(4'b0010, 4'b0000, 1'b0, 1);
        step(4'b0010, 4'b0000, 1'b1, -1);
        step(4'b0010, 4'b0000, 1'b0, 1);
        // Sparse single requester.
        step(4'b1000, 4'b0000, 1'b0, 3);
        step(4'b0000, 4'b0000, 1'b0, -1);
        step(4'b1000, 4'b0000, 1'b0, 3);
        step(4'b0000, 4'b0000, 1'b0, -1);
        step(4'b1000, 4'b0000, 1'b0, 3);
        // Reset in the middle of a locked burst.
        step(4'b1111, 4'b1111, 1'b0, 0);
        step(4'b1111, 4'b1111, 1'b0, 0);
        #2;
        check("rvalid_inflight", 32'(rvalid_o), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rvalid_async_rst", 32'(rvalid_o), 32'h0);
        check("rdata_async_rst", rdata_o, 32'h0);
        check("gnt_in_rst", 32'(gnt_o), 32'h0);
        rq.delete();
        step(4'b1111, 4'b0000, 1'b0, -1);
        rst_n = 1'b1;
        step(4'b1111, 4'b0000, 1'b0, 0);
        step(4'b1111, 4'b0000, 1'b0, 1);
        step(4'b0000, 4'b0000, 1'b0, -1);
        step(4'b0000, 4'b0000, 1'b0, -1);
        check("resp_queue_drained", 32'(rq.size()), 32'd0);
        check("gnt_queue_drained", 32'(gq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
